// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: steps fetch/decode/address/memory/execute/writeback
// over a shared memory port with a ready handshake, and gates architectural writes with CondEx.
module mc_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             CondEx,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemW,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegW,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   set_illegal;

    // Funct[2:1] carry no control information for this sequencer.
    logic unused_funct;
    assign unused_funct = ^Funct[2:1];

    assign state = state_q;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // A squashed store never asks for memory, so it retires immediately.
            S_MEMWRITE: begin
                if (!CondEx || mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        MemW      = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegW      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = CondEx;
            end
            S_MEMWRITE: begin
                mem_req = CondEx;
                MemW    = CondEx;
                AdrSrc  = CondEx;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            // Compare/test opcodes (Funct[4:3] = 10) only update flags.
            S_ALUWB: RegW = CondEx && (Funct[4:3] != 2'b10);
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = CondEx;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire)      retired <= retired + CNT_W'(1);
            if (set_illegal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm: walks each instruction class through its
// state sequence and compares control outputs against hand-derived values.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_MEMADR = 4'd3, ST_MEMREAD = 4'd4, ST_MEMWB = 4'd5,
                           ST_MEMWRITE = 4'd6, ST_EXECUTER = 4'd7, ST_EXECUTEI = 4'd8,
                           ST_ALUWB = 4'd9, ST_BRANCH = 4'd10;

    // {mem_req, MemW, AdrSrc, IRWrite, PCWrite, RegW, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
    localparam logic [11:0] C_ZERO       = 12'b0_0_0_0_0_0_0_00_00_0;
    localparam logic [11:0] C_FETCH_RDY  = 12'b1_0_0_1_1_0_1_10_10_0;
    localparam logic [11:0] C_FETCH_WAIT = 12'b1_0_0_0_0_0_1_10_10_0;
    localparam logic [11:0] C_DECODE     = 12'b0_0_0_0_0_0_1_10_10_0;
    localparam logic [11:0] C_MEMADR     = 12'b0_0_0_0_0_0_0_01_00_0;
    localparam logic [11:0] C_MEMREAD    = 12'b1_0_1_0_0_0_0_00_00_0;
    localparam logic [11:0] C_MEMWB_W    = 12'b0_0_0_0_0_1_0_00_01_0;
    localparam logic [11:0] C_MEMWR      = 12'b1_1_1_0_0_0_0_00_00_0;
    localparam logic [11:0] C_EXER       = 12'b0_0_0_0_0_0_0_00_00_1;
    localparam logic [11:0] C_EXEI       = 12'b0_0_0_0_0_0_0_01_00_1;
    localparam logic [11:0] C_ALUWB_W    = 12'b0_0_0_0_0_1_0_00_00_0;
    localparam logic [11:0] C_BR_TAKEN   = 12'b0_0_0_0_1_0_0_01_10_0;
    localparam logic [11:0] C_BR_NOT     = 12'b0_0_0_0_0_0_0_01_10_0;

    logic             clk;
    logic             rst_n;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             CondEx;
    logic             mem_ready;
    logic             mem_req;
    logic             MemW;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegW;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             ALUOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    logic [11:0] ctrl;
    assign ctrl = {mem_req, MemW, AdrSrc, IRWrite, PCWrite, RegW, ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

    int n_cmp = 0;
    int n_err = 0;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .CondEx(CondEx),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemW(MemW), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegW(RegW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .state(state),
        .retired(retired), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [11:0] c);
        check({tag, ".state"}, {28'd0, state}, {28'd0, st});
        check({tag, ".ctrl"}, {20'd0, ctrl}, {20'd0, c});
    endtask

    task automatic expect_retired(input string tag, input logic [CNT_W-1:0] r);
        check(tag, {28'd0, retired}, {28'd0, r});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends in FETCH with mem_ready = 1.
    task automatic run_branch(input logic c);
        Op = 2'b10; Funct = 6'b000000; CondEx = c;
        step();
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; Op = 2'b00; Funct = 6'b101000; CondEx = 1'b1; mem_ready = 1'b1;
        step();
        step();
        expect_cycle("reset", ST_IDLE, C_ZERO);
        expect_retired("reset.retired", 4'd0);
        check("reset.illegal", {31'd0, illegal}, 32'd0);

        rst_n = 1'b1;
        #1;
        expect_cycle("idle", ST_IDLE, C_ZERO);

        // ADD immediate, CondEx = 1
        step();
        expect_cycle("add.fetch", ST_FETCH, C_FETCH_RDY);
        expect_retired("add.fetch.retired", 4'd0);
        step();
        expect_cycle("add.decode", ST_DECODE, C_DECODE);
        step();
        expect_cycle("add.execi", ST_EXECUTEI, C_EXEI);
        step();
        expect_cycle("add.aluwb", ST_ALUWB, C_ALUWB_W);
        expect_retired("add.aluwb.retired", 4'd0);

        // CMP register
        Funct = 6'b010101;
        step();
        expect_retired("add.done.retired", 4'd1);
        step();
        expect_cycle("cmp.decode", ST_DECODE, C_DECODE);
        step();
        expect_cycle("cmp.execr", ST_EXECUTER, C_EXER);
        step();
        expect_cycle("cmp.aluwb", ST_ALUWB, C_ZERO);

        // LDR with three wait cycles
        Op = 2'b01; Funct = 6'b011001;
        step();
        expect_retired("cmp.done.retired", 4'd2);
        step();
        step();
        expect_cycle("ldr.memadr", ST_MEMADR, C_MEMADR);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            expect_cycle($sformatf("ldr.memread%0d", i), ST_MEMREAD, C_MEMREAD);
            mem_ready = (i == 3);
            step();
        end
        expect_cycle("ldr.memwb", ST_MEMWB, C_MEMWB_W);

        // STR, CondEx = 1, fetch stall then store stall
        Funct = 6'b011000; mem_ready = 1'b0;
        step();
        expect_retired("ldr.done.retired", 4'd3);
        expect_cycle("str.fetch_wait", ST_FETCH, C_FETCH_WAIT);
        step();
        check("str.fetch_hold", {28'd0, state}, {28'd0, ST_FETCH});
        mem_ready = 1'b1;
        #1;
        check("str.fetch_rdy", {20'd0, ctrl}, {20'd0, C_FETCH_RDY});
        step();
        step();
        mem_ready = 1'b0;
        step();
        expect_cycle("str.memwr", ST_MEMWRITE, C_MEMWR);
        step();
        expect_cycle("str.memwr_hold", ST_MEMWRITE, C_MEMWR);
        mem_ready = 1'b1;
        step();
        expect_retired("str.done.retired", 4'd4);

        // STR, CondEx = 0: no request even though mem_ready is low
        CondEx = 1'b0;
        step();
        step();
        mem_ready = 1'b0;
        step();
        expect_cycle("strn.memwr", ST_MEMWRITE, C_ZERO);
        step();
        check("strn.next", {28'd0, state}, {28'd0, ST_FETCH});
        expect_retired("strn.done.retired", 4'd5);
        mem_ready = 1'b1;

        // Branch taken and not taken
        Op = 2'b10; Funct = 6'b000000; CondEx = 1'b1;
        step();
        step();
        expect_cycle("b.taken", ST_BRANCH, C_BR_TAKEN);
        CondEx = 1'b0;
        step();
        expect_retired("b.taken.retired", 4'd6);
        step();
        step();
        expect_cycle("b.not", ST_BRANCH, C_BR_NOT);
        step();
        expect_retired("b.not.retired", 4'd7);

        // Undefined opcode
        Op = 2'b11; CondEx = 1'b1;
        step();
        expect_cycle("ill.decode", ST_DECODE, C_DECODE);
        check("ill.before", {31'd0, illegal}, 32'd0);
        step();
        check("ill.state", {28'd0, state}, {28'd0, ST_FETCH});
        check("ill.set", {31'd0, illegal}, 32'd1);
        expect_retired("ill.retired", 4'd7);

        for (int i = 0; i < 8; i++) run_branch(1'b1);
        expect_retired("pre_rst.retired", 4'd15);
        check("ill.sticky", {31'd0, illegal}, 32'd1);

        // STR stalled in MEMWRITE, then asynchronous reset
        Op = 2'b01; Funct = 6'b011000; CondEx = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        expect_cycle("rst.memwr", ST_MEMWRITE, C_MEMWR);
        #2;
        rst_n = 1'b0;
        #1;
        expect_cycle("rst.async", ST_IDLE, C_ZERO);
        expect_retired("rst.retired", 4'd0);
        check("rst.illegal", {31'd0, illegal}, 32'd0);

        // Second run: 16 completions wrap the counter
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        expect_cycle("wrap.fetch", ST_FETCH, C_FETCH_RDY);
        for (int i = 0; i < 15; i++) run_branch(1'b0);
        expect_retired("wrap.15", 4'd15);
        run_branch(1'b1);
        expect_retired("wrap.16", 4'd0);
        check("wrap.state", {28'd0, state}, {28'd0, ST_FETCH});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
